// File: rtl/letc_core_mul_pipe.sv
// letc_core_mul_pipe: fully pipelined RISC-V M-extension multiplier
// (MUL, MULH, MULHSU, MULHU) for the LETC Core execute stage.
//
// Structure: one input flop stage, then STAGES pipeline stages. Stage 1 holds
// the product. Stages 2..STAGES are plain registers left as retiming slack
// for DSP inference. Latency is 1 + STAGES cycles, and throughput is one op
// per cycle.
//
// Optional feature: define LETC_CORE_MUL_PIPE_FLUSH_EN to add an i_flush
// input. A flush drops every in-flight op, including the op accepted on the
// same edge.
//
// Data and tag registers load only when a valid op moves into them. This
// means o_product, o_result and o_tag keep showing the last delivered op
// during bubbles, and stay zero from reset until the first result.

module letc_core_mul_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STAGES    = 4,
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
`ifdef LETC_CORE_MUL_PIPE_FLUSH_EN
    input  logic                   i_flush,
`endif
    input  logic                   i_valid,
    input  logic [1:0]             i_op,
    input  logic [WIDTH-1:0]       i_rs1,
    input  logic [WIDTH-1:0]       i_rs2,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_result,
    output logic [2*WIDTH-1:0]     o_product,
    output logic [TAG_WIDTH-1:0]   o_tag,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        OpMul    = 2'b00,
        OpMulh   = 2'b01,
        OpMulhsu = 2'b10,
        OpMulhu  = 2'b11
    } op_e;

    // Flush request. It is tied low when the feature is compiled out.
    logic flush;
`ifdef LETC_CORE_MUL_PIPE_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Input flop stage
    // ------------------------------------------------------------------
    logic                 in_valid_q;
    op_e                  in_op_q;
    logic [WIDTH-1:0]     in_rs1_q;
    logic [WIDTH-1:0]     in_rs2_q;
    logic [TAG_WIDTH-1:0] in_tag_q;

    logic                 in_load;
    assign in_load = i_valid & ~flush;

    // Capture the incoming op. Operand and tag registers load only for a
    // real op.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            in_valid_q <= 1'b0;
            in_op_q    <= OpMul;
            in_rs1_q   <= '0;
            in_rs2_q   <= '0;
            in_tag_q   <= '0;
        end else begin
            in_valid_q <= in_load;
            if (in_load) begin
                in_op_q  <= op_e'(i_op);
                in_rs1_q <= i_rs1;
                in_rs2_q <= i_rs2;
                in_tag_q <= i_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 arithmetic
    // ------------------------------------------------------------------
    // The product of the (WIDTH+1)-bit signed operands is only needed modulo
    // 2^(2*WIDTH). Extending each operand straight to 2*WIDTH bits with the
    // same sign rule gives identical low bits. An unsigned 2*WIDTH multiply
    // then yields exactly those bits, with no unused upper bits.
    logic                 rs1_signed;
    logic                 rs2_signed;
    logic [2*WIDTH-1:0]   rs1_ext;
    logic [2*WIDTH-1:0]   rs2_ext;
    logic [2*WIDTH-1:0]   prod_d;

    // Select operand signedness from the op and form the extended product.
    always_comb begin
        rs1_signed = (in_op_q == OpMulh) || (in_op_q == OpMulhsu);
        rs2_signed = (in_op_q == OpMulh);
        rs1_ext    = {{WIDTH{rs1_signed & in_rs1_q[WIDTH-1]}}, in_rs1_q};
        rs2_ext    = {{WIDTH{rs2_signed & in_rs2_q[WIDTH-1]}}, in_rs2_q};
        prod_d     = rs1_ext * rs2_ext;
    end

    // ------------------------------------------------------------------
    // Pipeline stages 1..STAGES (index 0..STAGES-1)
    // ------------------------------------------------------------------
    logic [STAGES-1:0]    valid_q;
    op_e                  op_q   [STAGES];
    logic [TAG_WIDTH-1:0] tag_q  [STAGES];
    logic [2*WIDTH-1:0]   prod_q [STAGES];

    // Advance valid, op, tag and product in lockstep. A flush clears every
    // valid bit and freezes the data registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                op_q[i]   <= OpMul;
                tag_q[i]  <= '0;
                prod_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_q & ~flush;
            if (in_valid_q & ~flush) begin
                op_q[0]   <= in_op_q;
                tag_q[0]  <= in_tag_q;
                prod_q[0] <= prod_d;
            end
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1] & ~flush;
                if (valid_q[i-1] & ~flush) begin
                    op_q[i]   <= op_q[i-1];
                    tag_q[i]  <= tag_q[i-1];
                    prod_q[i] <= prod_q[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Drive outputs from the last stage and pick the architectural half.
    always_comb begin
        o_valid   = valid_q[STAGES-1];
        o_product = prod_q[STAGES-1];
        o_tag     = tag_q[STAGES-1];
        o_result  = (op_q[STAGES-1] == OpMul) ? prod_q[STAGES-1][WIDTH-1:0]
                                              : prod_q[STAGES-1][2*WIDTH-1:WIDTH];
        o_busy    = in_valid_q | (|valid_q);
    end

`ifdef SIMULATION
    // o_valid must never be unknown once reset has been released.
    always @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!$isunknown(o_valid)) else $error("o_valid is X after reset release");
        end
    end
`endif

endmodule

// File: tb/tb_letc_core_mul_pipe.sv
// Self-checking bench for letc_core_mul_pipe (WIDTH=32, STAGES=4).
// The reference model computes each product from the M-extension rules with
// 64-bit integer arithmetic. Expected results are queued together with the
// edge at which they are due.

module tb_letc_core_mul_pipe;

    localparam int unsigned W   = 32;
    localparam int unsigned ST  = 4;
    localparam int unsigned TW  = 5;
    localparam int unsigned LAT = ST;  // edges after the sampling edge

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic [1:0]    i_op;
    logic [W-1:0]  i_rs1;
    logic [W-1:0]  i_rs2;
    logic [TW-1:0] i_tag;
    logic          o_valid;
    logic [W-1:0]  o_result;
    logic [2*W-1:0] o_product;
    logic [TW-1:0] o_tag;
    logic          o_busy;
`ifdef LETC_CORE_MUL_PIPE_FLUSH_EN
    logic          i_flush;
`endif

    always #5 i_clk = ~i_clk;

    letc_core_mul_pipe #(
        .WIDTH     (W),
        .STAGES    (ST),
        .TAG_WIDTH (TW)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
`ifdef LETC_CORE_MUL_PIPE_FLUSH_EN
        .i_flush   (i_flush),
`endif
        .i_valid   (i_valid),
        .i_op      (i_op),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_tag     (i_tag),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_product (o_product),
        .o_tag     (o_tag),
        .o_busy    (o_busy)
    );

    typedef struct {
        int             due;
        logic [2*W-1:0] prod;
        logic [W-1:0]   res;
        logic [TW-1:0]  tag;
    } exp_t;

    exp_t           q[$];
    int             edge_cnt = 0;
    int             tests    = 0;
    int             fails    = 0;
    logic [2*W-1:0] last_prod = '0;
    logic [W-1:0]   last_res  = '0;
    logic [TW-1:0]  last_tag  = '0;

    // Reference: the signed value of each operand times the other, kept mod 2^64.
    function automatic logic [2*W-1:0] ref_prod(input logic [1:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        longint sa, sb;
        sa = (op == 2'd1 || op == 2'd2) ? longint'($signed(a)) : longint'({32'd0, a});
        sb = (op == 2'd1) ? longint'($signed(b)) : longint'({32'd0, b});
        return 64'(sa * sb);
    endfunction

    task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Compare the outputs after an edge against the model queue.
    task automatic check_out();
        logic exp_busy;
        exp_busy = (q.size() != 0);
        if (q.size() != 0 && q[0].due == edge_cnt) begin
            chk("valid", 64'(o_valid), 64'd1);
            chk("product", o_product, q[0].prod);
            chk("result", 64'(o_result), 64'(q[0].res));
            chk("tag", 64'(o_tag), 64'(q[0].tag));
            last_prod = q[0].prod;
            last_res  = q[0].res;
            last_tag  = q[0].tag;
            void'(q.pop_front());
        end else begin
            chk("idle_valid", 64'(o_valid), 64'd0);
            chk("hold_product", o_product, last_prod);
            chk("hold_result", 64'(o_result), 64'(last_res));
            chk("hold_tag", 64'(o_tag), 64'(last_tag));
        end
        chk("busy", 64'(o_busy), 64'(exp_busy));
    endtask

    // Present one cycle of input, clock it, then check the outputs 1 time unit later.
    task automatic step(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] tg);
        exp_t e;
        i_valid = v;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        i_tag   = tg;
        @(posedge i_clk);
        edge_cnt++;
        if (v) begin
            e.due  = edge_cnt + LAT;
            e.prod = ref_prod(op, a, b);
            e.res  = (op == 2'd0) ? e.prod[W-1:0] : e.prod[2*W-1:W];
            e.tag  = tg;
            q.push_back(e);
        end
        #1;
        i_valid = 1'b0;
        check_out();
    endtask

    task automatic bubble();
        step(1'b0, 2'($urandom), $urandom, $urandom, TW'($urandom));
    endtask

    // Issue one op, wait until it is due, and compare against literal values.
    task automatic run_lit(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [TW-1:0] tg,
                           input logic [2*W-1:0] xp, input logic [W-1:0] xr);
        step(1'b1, op, a, b, tg);
        for (int i = 0; i < int'(LAT); i++) bubble();
        chk({name, "_valid"}, 64'(o_valid), 64'd1);
        chk({name, "_product"}, o_product, xp);
        chk({name, "_result"}, 64'(o_result), 64'(xr));
        chk({name, "_tag"}, 64'(o_tag), 64'(tg));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset with i_valid held high: it must be ignored.
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_op    = 2'd3;
        i_rs1   = 32'hFFFF_FFFF;
        i_rs2   = 32'h1234_5678;
        i_tag   = 5'd9;
`ifdef LETC_CORE_MUL_PIPE_FLUSH_EN
        i_flush = 1'b0;
`endif
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_product", o_product, 64'd0);
        chk("rst_result", 64'(o_result), 64'd0);
        chk("rst_tag", 64'(o_tag), 64'd0);
        i_valid = 1'b0;
        i_rst   = 1'b0;
        for (int i = 0; i < 3; i++) bubble();

        // Directed corners.
        run_lit("mulhu_ff", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
                64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE);
        run_lit("mulh_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,
                64'h0000_0000_0000_0001, 32'h0000_0000);
        run_lit("mulh_80", 2'd1, 32'h8000_0000, 32'h8000_0000, 5'd5,
                64'h4000_0000_0000_0000, 32'h4000_0000);
        run_lit("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
                64'hFFFF_FFFE_0000_0001, 32'h0000_0001);
        run_lit("mulhsu_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
                64'hFFFF_FFFF_0000_0001, 32'hFFFF_FFFF);

        // Streaming: 8 back-to-back ops, one bubble, then 2 more ops.
        for (int i = 0; i < 8; i++) step(1'b1, 2'($urandom), pick_operand(), pick_operand(), TW'(i));
        bubble();
        for (int i = 0; i < 2; i++) step(1'b1, 2'($urandom), pick_operand(), pick_operand(), TW'(8 + i));
        for (int i = 0; i < 6; i++) bubble();

        // Randomised traffic with random bubbles.
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom), pick_operand(), pick_operand(),
                 TW'($urandom));
        end
        for (int i = 0; i < 6; i++) bubble();

        // Reset asserted between edges with 3 ops in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 2'($urandom), $urandom, $urandom, TW'(20 + i));
        #3;
        i_rst = 1'b1;
        #1;
        q.delete();
        last_prod = '0;
        last_res  = '0;
        last_tag  = '0;
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_busy", 64'(o_busy), 64'd0);
        chk("midrst_product", o_product, 64'd0);
        @(posedge i_clk);
        edge_cnt++;
        #1;
        chk("inrst_valid", 64'(o_valid), 64'd0);
        i_rst = 1'b0;
        for (int i = 0; i < 10; i++) bubble();
        run_lit("mul_7x6", 2'd0, 32'd7, 32'd6, 5'd11, 64'd42, 32'd42);
        for (int i = 0; i < 2; i++) bubble();

`ifdef LETC_CORE_MUL_PIPE_FLUSH_EN
        // Flush with 4 ops in flight plus a new op on the same edge.
        for (int i = 0; i < 4; i++) step(1'b1, 2'($urandom), $urandom, $urandom, TW'(12 + i));
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_op    = 2'd0;
        i_rs1   = 32'd9;
        i_rs2   = 32'd9;
        i_tag   = 5'd16;
        @(posedge i_clk);
        edge_cnt++;
        q.delete();
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_busy", 64'(o_busy), 64'd0);
        run_lit("mul_3x5", 2'd0, 32'd3, 32'd5, 5'd17, 64'd15, 32'd15);
        for (int i = 0; i < 6; i++) bubble();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/letc_core_mul_pipe.md
Name: letc_core_mul_pipe

Overview:
- Parametrised, fully pipelined integer multiplier for the LETC Core execute stage. Implements RISC-V M-extension multiply variants: MUL, MULH, MULHSU and MULHU.
- Accepts one operation per cycle with no backpressure. Returns a full double-width product, the architecturally selected half, and a caller tag (e.g. rd index) after a fixed latency.
- Replaces the fixed 32-bit unsigned-only multiplier.

Parameters:
- WIDTH, 32, operand width in bits (≥ 8).
- STAGES, 4, multiplier pipeline stages after the input flop stage (≥ 1); retiming target for DSP inference.
- TAG_WIDTH, 5, width of the opaque tag carried alongside each operation (≥ 1).

Ports:
- i_clk  input  1  core clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operation present this cycle.
- i_op  input  2  00=MUL, 01=MULH (s×s), 10=MULHSU (rs1 signed × rs2 unsigned), 11=MULHU (u×u).
- i_rs1  input  WIDTH  first operand.
- i_rs2  input  WIDTH  second operand.
- i_tag  input  TAG_WIDTH  opaque tag, returned unchanged.
- o_valid  output  1  result valid this cycle.
- o_result  output  WIDTH  selected half: low half for MUL, high half otherwise.
- o_product  output  2*WIDTH  full 2*WIDTH product under the signedness of i_op.
- o_tag  output  TAG_WIDTH  tag of the returning operation.
- o_busy  output  1  any stage, including the input flop, holds a valid operation.

Behaviour:
- Reset (async assert, sync release) clears every valid bit and data/tag register to 0. All outputs read 0 while i_rst is high and until the first valid result.
- Latency: exactly 1 + STAGES cycles. An op sampled with i_valid=1 at edge N appears with o_valid=1 in the cycle after edge N+STAGES. Default latency is 5.
- Throughput: 1 op/cycle. Back-to-back ops return in order on consecutive cycles. Bubbles propagate as o_valid=0.
- Input stage registers i_valid, i_op, i_rs1, i_rs2 and i_tag.
- Arithmetic in stage 1:
  - Extend rs1 to WIDTH+1 bits: sign-extend for MULH/MULHSU, zero-extend otherwise.
  - Extend rs2 to WIDTH+1 bits: sign-extend for MULH only, zero-extend otherwise.
  - Multiply the extended operands as signed (WIDTH+1)×(WIDTH+1). o_product is the low 2*WIDTH bits of the result.
  - MUL's low half is identical for all signedness choices.
- Stages 2..STAGES are plain registers (retiming slack). Valid, op and tag travel in lockstep with the data.
- o_result = o_product[WIDTH-1:0] when the delivered op is MUL, else o_product[2*WIDTH-1:WIDTH].
- When o_valid=0, data and tag outputs hold their previous register contents; consumers must qualify with o_valid.
- o_busy is the combinational OR of all internal valid bits. It does not include i_valid.
- Reset mid-operation: all in-flight ops are discarded immediately. o_valid and o_busy drop in the same cycle i_rst rises. No stale result emerges after release.
- i_valid is ignored while i_rst is high.
- No division, no operand-dependent early-out: latency is constant for all operands.

Optional Feature:
- Macro: LETC_CORE_MUL_PIPE_FLUSH_EN.
- Defined:
  - Adds input port i_flush (1 bit).
  - i_flush=1 at an edge clears every internal valid bit at that edge, including an op being accepted via i_valid the same cycle. o_valid and o_busy are 0 the following cycle.
  - Data and tag registers are not cleared.
  - Ops accepted in the cycle after the flush proceed normally.
- Undefined: i_flush does not exist; the only way to discard in-flight ops is i_rst.
- Under SIMULATION, an assertion checks that o_valid is never X after reset release.

Test Plan:
- WIDTH=32, STAGES=4. MULHU 0xFFFFFFFF × 0xFFFFFFFF, tag 3 -> 5 cycles later: o_valid=1, o_product=0xFFFFFFFE00000001, o_result=0xFFFFFFFE, o_tag=3.
- Signed corners:
  - MULH 0xFFFFFFFF × 0xFFFFFFFF -> o_product=0x0000000000000001, o_result=0x00000000.
  - MULH 0x80000000 × 0x80000000 -> o_result=0x40000000.
  - MUL 0xFFFFFFFF × 0xFFFFFFFF -> o_result=0x00000001.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> o_product=0xFFFFFFFF00000001, o_result=0xFFFFFFFF. Same operands with MULHU give a different high half (0xFFFFFFFE).
- Streaming and ordering:
  - 8 back-to-back ops with tags 0..7, then a 1-cycle bubble, then 2 ops -> tags emerge 0..7 on consecutive cycles, one o_valid=0 gap, then 2 more.
  - o_busy=1 from the cycle after the first op until the last result cycle.
- Reset mid-flight: 3 ops in flight, assert i_rst asynchronously between edges -> o_valid=0 and o_busy=0 immediately. No results appear for 10 cycles after release. A fresh MUL 7×6 then returns o_result=42 after 5 cycles.
- With LETC_CORE_MUL_PIPE_FLUSH_EN:
  - 4 ops in flight plus i_flush=1 together with a new i_valid -> zero results emerge.
  - An op issued the next cycle (MUL 3×5) returns o_result=15 with latency 5.
